// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles the signals between the fetch stage, the pipeline controller, the
// instruction cache and decode. Signal suffixes are written from the point of
// view of the fetch stage (_i = into fetch, _o = out of fetch).
//
//   pcSel_i       2   next-PC select: 0=PLUS4, 1=ALU redirect, 2=JAL, 3=PLUS4
//   aluTarget_i   32  redirect target from the X-stage ALU
//   jalTarget_i   32  jump target computed in I
//   instKill_i    1   squash the instruction presented this cycle
//   stall_i       1   downstream hold request
//   icacheRe_o    1   ICache read enable
//   icacheAddr_o  32  ICache read address (next fetch PC)
//   icacheDout_i  32  ICache read data, one cycle after the address
//   icacheValid_i 1   ICache data valid (0 = miss / not ready)
//   inst_o        32  instruction to decode
//   instPc_o      32  PC of inst_o
//   instValid_o   1   inst_o is a real, non-squashed instruction
//   fetchCnt_o    32  cycles with a valid, non-stalled instruction
//   bubbleCnt_o   32  cycles without a valid instruction (after boot)
//
// Modports: slave = the fetch stage, master = controller/cache/decode side.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic [1:0]  pcSel_i;
  logic [31:0] aluTarget_i;
  logic [31:0] jalTarget_i;
  logic        instKill_i;
  logic        stall_i;
  logic        icacheRe_o;
  logic [31:0] icacheAddr_o;
  logic [31:0] icacheDout_i;
  logic        icacheValid_i;
  logic [31:0] inst_o;
  logic [31:0] instPc_o;
  logic        instValid_o;
  logic [31:0] fetchCnt_o;
  logic [31:0] bubbleCnt_o;

  modport slave (
    input  pcSel_i, aluTarget_i, jalTarget_i, instKill_i, stall_i,
           icacheDout_i, icacheValid_i,
    output icacheRe_o, icacheAddr_o, inst_o, instPc_o, instValid_o,
           fetchCnt_o, bubbleCnt_o
  );

  modport master (
    output pcSel_i, aluTarget_i, jalTarget_i, instKill_i, stall_i,
           icacheDout_i, icacheValid_i,
    input  icacheRe_o, icacheAddr_o, inst_o, instPc_o, instValid_o,
           fetchCnt_o, bubbleCnt_o
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 3-stage Riscv151 pipeline. Owns the fetch PC,
// drives the synchronous (1-cycle latency) ICache and presents each returned
// instruction together with its PC to decode. Handles stalls (holding the
// presented instruction), cache misses (re-reading the same PC), ALU redirects
// (squashing the presented instruction) and JAL redirects, and keeps fetch and
// bubble counters for the CSR file.
//
// Ports
//   clk    1   clock, all state updates on the rising edge
//   rst_n  1   asynchronous reset, active low
//   bus        fetch_stage_if.slave (see fetch_stage_if.sv for signals)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_stage_if.slave bus
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pcF_q, pcF_d;
  logic [31:0] holdInst_q, holdInst_d;
  logic        holdValid_q, holdValid_d;
  logic        kill_q, kill_d;
  logic [31:0] fetchCnt_q, fetchCnt_d;
  logic [31:0] bubbleCnt_q, bubbleCnt_d;

  logic        booting;
  logic        redirect;
  logic        waitData;
  logic        instValid;
  logic [31:0] nextPc;

  // Next fetch PC and the validity of the instruction presented this cycle.
  // An ALU redirect outranks a stall or miss because the presented instruction
  // is on the wrong path anyway; a JAL only applies once the current
  // instruction has actually been accepted.
  always_comb begin
    booting  = (state_q == S_BOOT);
    redirect = !booting && (bus.pcSel_i == 2'd1);
    waitData = bus.stall_i || !bus.icacheValid_i;

    if (booting)                    nextPc = RESET_PC;
    else if (redirect)              nextPc = bus.aluTarget_i;
    else if (waitData)              nextPc = pcF_q;
    else if (bus.pcSel_i == 2'd2)   nextPc = bus.jalTarget_i;
    else                            nextPc = pcF_q + 32'd4;

    instValid = !booting && bus.icacheValid_i && !bus.instKill_i &&
                !redirect && !kill_q;
  end

  // Next-state values for the FSM, the stall hold register, the sticky kill
  // flag and the performance counters.
  always_comb begin
    state_d = waitData && !booting ? S_WAIT : S_RUN;
    pcF_d   = nextPc;

    // The BRAM output is not guaranteed stable while stalled, so the first
    // valid word seen during a stall is captured and replayed until release.
    // A redirect discards it because the held word belongs to the old path.
    holdValid_d = holdValid_q;
    holdInst_d  = holdInst_q;
    if (booting || redirect || !bus.stall_i) begin
      holdValid_d = 1'b0;
    end else if (!holdValid_q && bus.icacheValid_i) begin
      holdValid_d = 1'b1;
      holdInst_d  = bus.icacheDout_i;
    end

    // A kill that arrives during a stall must survive the stall, otherwise
    // the held instruction would reappear as valid on the next cycle. The
    // redirect case clears it since the held instruction is replaced.
    kill_d = kill_q;
    if (booting || redirect || !bus.stall_i) begin
      kill_d = 1'b0;
    end else if (bus.instKill_i) begin
      kill_d = 1'b1;
    end

    fetchCnt_d  = fetchCnt_q + {31'd0, (instValid && !bus.stall_i)};
    bubbleCnt_d = bubbleCnt_q + {31'd0, (!instValid && !booting)};
  end

  // State registers; reset returns everything to the boot condition at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      pcF_q       <= RESET_PC;
      holdInst_q  <= NOP_INST;
      holdValid_q <= 1'b0;
      kill_q      <= 1'b0;
      fetchCnt_q  <= 32'd0;
      bubbleCnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pcF_q       <= pcF_d;
      holdInst_q  <= holdInst_d;
      holdValid_q <= holdValid_d;
      kill_q      <= kill_d;
      fetchCnt_q  <= fetchCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  // The cache is read every cycle outside reset; a miss simply re-reads.
  assign bus.icacheRe_o   = rst_n;
  assign bus.icacheAddr_o = nextPc;
  assign bus.instPc_o     = pcF_q;
  assign bus.instValid_o  = instValid;
  assign bus.inst_o       = !instValid   ? NOP_INST :
                            holdValid_q  ? holdInst_q : bus.icacheDout_i;
  assign bus.fetchCnt_o   = fetchCnt_q;
  assign bus.bubbleCnt_o  = bubbleCnt_q;

endmodule
